// File: rtl/bcd2bin_n.sv
// Iterative BCD-to-binary converter using reverse double-dabble.
// DIGITS packed BCD digits in, BIN_W-bit registered binary result out.
module bcd2bin_n #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  err,
  output logic                  ready,
  output logic                  done_tick
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP,
    S_BAD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BIN_W-1:0]  wrk_q, wrk_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [BW+BIN_W-1:0] shf;
  logic [BW-1:0]       shf_bcd;
  logic [BW-1:0]       adj;
  logic                in_bad;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // One iteration: shift the joint register, then undo the
  // halved decimal carry in every digit that landed at >= 8.
  always_comb begin
    shf     = {bcd_q, wrk_q} >> 1;
    shf_bcd = shf[BIN_W +: BW];
    adj     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (shf_bcd[4*i +: 4] >= 4'd8)
        adj[4*i +: 4] = shf_bcd[4*i +: 4] - 4'd3;
      else
        adj[4*i +: 4] = shf_bcd[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    wrk_d   = wrk_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d = bcd;
          wrk_d = '0;
          if (in_bad) begin
            cnt_d   = '0;
            state_d = S_BAD;
          end else begin
            cnt_d   = CW'(BIN_W);
            state_d = S_OP;
          end
        end
      end
      S_OP: begin
        bcd_d = adj;
        wrk_d = shf[BIN_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          bin_d   = shf[BIN_W-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_BAD: begin
        bin_d   = '0;
        err_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      wrk_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      wrk_q   <= wrk_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bin       = bin_q;
  assign err       = err_q;
  assign ready     = (state_q == S_IDLE);
  assign done_tick = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd2bin_n.sv
// Self-checking bench for bcd2bin_n: 4-digit and 2-digit instances,
// directed plan items plus randomized jobs against a decimal model.
module tb_bcd2bin_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, st4;
  logic [15:0] bcd4;
  logic [13:0] bin4;
  logic        err4, rdy4, dt4;

  logic        rst2, st2;
  logic [7:0]  bcd2;
  logic [6:0]  bin2;
  logic        err2, rdy2, dt2;

  int errors = 0;
  int checks = 0;

  bcd2bin_n #(.DIGITS(4), .BIN_W(14)) dut4 (
    .clk(clk), .reset(rst4), .start(st4), .bcd(bcd4),
    .bin(bin4), .err(err4), .ready(rdy4), .done_tick(dt4)
  );

  bcd2bin_n #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk(clk), .reset(rst2), .start(st2), .bcd(bcd2),
    .bin(bin2), .err(err2), .ready(rdy2), .done_tick(dt2)
  );

  // Decimal value of the digits, most significant first.
  function automatic void ref_model(input logic [31:0] b, input int nd,
                                    output int val, output bit bad);
    int d;
    val = 0;
    bad = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'((b >> (4 * i)) & 32'hF);
      if (d > 9) bad = 1'b1;
      val = val * 10 + d;
    end
    if (bad) val = 0;
  endfunction

  task automatic go4(input logic [15:0] v, output int lat, output int rdylow);
    bcd4 = v;
    st4  = 1'b1;
    @(posedge clk); #1;
    st4    = 1'b0;
    lat    = 0;
    rdylow = 0;
    if (!rdy4) rdylow++;
    while (!dt4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!rdy4) rdylow++;
    end
  endtask

  task automatic go2(input logic [7:0] v, output int lat);
    bcd2 = v;
    st2  = 1'b1;
    @(posedge clk); #1;
    st2 = 1'b0;
    lat = 0;
    while (!dt2 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst2 = 1'b1;
    st4 = 1'b0; st2 = 1'b0; bcd4 = '0; bcd2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bin4, err4, rdy4, dt4} !== {14'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset4 got bin=%0d err=%b rdy=%b dt=%b want 0 0 1 0",
               bin4, err4, rdy4, dt4);
    end
    checks++;
    if ({bin2, err2, rdy2, dt2} !== {7'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset2 got bin=%0d err=%b rdy=%b dt=%b want 0 0 1 0",
               bin2, err2, rdy2, dt2);
    end
    rst4 = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] vals [6];
    int lat, rl, ev;
    bit bad;
    vals = '{16'h9999, 16'h0097, 16'h0000, 16'h1000, 16'h12A4, 16'h0042};
    foreach (vals[k]) begin
      ref_model({16'h0, vals[k]}, 4, ev, bad);
      go4(vals[k], lat, rl);
      checks++;
      if (lat !== (bad ? 1 : 14)) begin
        errors++;
        $display("FAIL dir_lat %h got %0d want %0d", vals[k], lat, bad ? 1 : 14);
      end
      checks++;
      if (bin4 !== 14'(ev) || err4 !== bad) begin
        errors++;
        $display("FAIL dir_res %h got bin=%0d err=%b want bin=%0d err=%b",
                 vals[k], bin4, err4, ev, bad);
      end
      if (k == 0) begin
        checks++;
        if (rl !== 15) begin
          errors++;
          $display("FAIL dir_rdylow got %0d want 15", rl);
        end
      end
      if (!bad) begin
        checks++;
        if (dut4.bcd_q !== 16'h0) begin
          errors++;
          $display("FAIL dir_bcdzero got %h want 0", dut4.bcd_q);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (rdy4 !== 1'b1 || dt4 !== 1'b0 || bin4 !== 14'(ev)) begin
        errors++;
        $display("FAIL dir_post %h got rdy=%b dt=%b bin=%0d want 1 0 %0d",
                 vals[k], rdy4, dt4, bin4, ev);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int lat, rl, ev;
    bit bad;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        v = 16'($urandom);
      end else begin
        v = '0;
        for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      ref_model({16'h0, v}, 4, ev, bad);
      go4(v, lat, rl);
      checks++;
      if (lat !== (bad ? 1 : 14) || bin4 !== 14'(ev) || err4 !== bad) begin
        errors++;
        $display("FAIL rand %h got lat=%0d bin=%0d err=%b want lat=%0d bin=%0d err=%b",
                 v, lat, bin4, err4, bad ? 1 : 14, ev, bad);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_held_start();
    int lat, dts, cyc;
    bcd2 = 8'h97;
    st2  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    st2 = 1'b0;
    cyc = 2;
    dts = 0;
    while (!dt2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 7 || bin2 !== 7'd97 || err2 !== 1'b0) begin
      errors++;
      $display("FAIL held_first got lat=%0d bin=%0d err=%b want 7 97 0",
               cyc, bin2, err2);
    end
    @(posedge clk); #1;
    checks++;
    if (rdy2 !== 1'b1) begin
      errors++;
      $display("FAIL held_ready got %b want 1", rdy2);
    end
    go2(8'h97, lat);
    checks++;
    if (lat !== 7 || bin2 !== 7'd97 || err2 !== 1'b0) begin
      errors++;
      $display("FAIL held_second got lat=%0d bin=%0d err=%b want 7 97 0",
               lat, bin2, err2);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dt2) dts++;
    end
    checks++;
    if (dts !== 0) begin
      errors++;
      $display("FAIL held_extra got %0d extra done ticks want 0", dts);
    end
  endtask

  task automatic test_reset_mid();
    int lat, rl, dts;
    bcd4 = 16'h4321;
    st4  = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    checks++;
    if ({bin4, err4, rdy4, dt4} !== {14'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midrst got bin=%0d err=%b rdy=%b dt=%b want 0 0 1 0",
               bin4, err4, rdy4, dt4);
    end
    dts = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dt4) dts++;
    end
    checks++;
    if (dts !== 0) begin
      errors++;
      $display("FAIL midrst_tick got %0d want 0", dts);
    end
    go4(16'h0050, lat, rl);
    checks++;
    if (lat !== 14 || bin4 !== 14'd50 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next got lat=%0d bin=%0d err=%b want 14 50 0",
               lat, bin4, err4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int dts;
    logic [13:0] got;
    got  = '0;
    bcd4 = 16'h1234;
    st4  = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bcd4 = 16'h5678;
    st4  = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    dts = 0;
    for (int i = 0; i < 20; i++) begin
      if (dt4) begin dts++; got = bin4; end
      @(posedge clk); #1;
    end
    checks++;
    if (dts !== 1 || got !== 14'd1234 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL ignore got ticks=%0d bin=%0d err=%b want 1 1234 0",
               dts, got, err4);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    int ev, gap, prev;
    bit bad;
    vals = '{16'h0815, 16'h2468, 16'h9001};
    bcd4 = vals[0];
    st4  = 1'b1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      @(posedge clk); #1;
      gap++;
      while (!dt4 && gap < 100) begin
        @(posedge clk); #1;
        gap++;
      end
      ref_model({16'h0, vals[k]}, 4, ev, bad);
      checks++;
      if (bin4 !== 14'(ev) || err4 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_res %0d got bin=%0d err=%b want %0d 0",
                 k, bin4, err4, ev);
      end
      if (k > 0) begin
        checks++;
        if (gap !== 16) begin
          errors++;
          $display("FAIL b2b_gap %0d got %0d want 16", k, gap);
        end
      end
      if (k < 2) bcd4 = vals[k+1];
      else st4 = 1'b0;
      prev = gap;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rdy4 !== 1'b1 || prev == 0) begin
      errors++;
      $display("FAIL b2b_idle got rdy=%b want 1", rdy4);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_held_start();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
